// File: rtl/div_seq.sv
// div_seq: multicycle restoring shift-subtract divider (signed/unsigned), one quotient bit per cycle.
// Optional macro DIV_ZERO_CHECK_EN enables the divide-by-zero reject path and the div_zero pulse.
`default_nettype none

module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_start,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             quo_neg_q, quo_neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div_zero_q, div_zero_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic             zero_reject;

  always_comb begin
`ifdef DIV_ZERO_CHECK_EN
    zero_reject = (divisor == '0);
`else
    zero_reject = 1'b0;
`endif
    a_abs   = (div_signed && dividend[WIDTH-1]) ? (~dividend + 1'b1) : dividend;
    b_abs   = (div_signed && divisor[WIDTH-1])  ? (~divisor + 1'b1)  : divisor;
    // Shifted partial remainder needs WIDTH+1 bits; one extra bit carries the trial sign.
    shifted = {1'b0, rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {2'b00, dvs_q};

    state_d     = state_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    cnt_d       = cnt_q;
    quo_neg_d   = quo_neg_q;
    rem_neg_d   = rem_neg_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    div_zero_d  = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (div_start && zero_reject) begin
          div_zero_d = 1'b1;
        end else if (div_start) begin
          quo_d     = a_abs;
          dvs_d     = b_abs;
          rem_d     = '0;
          cnt_d     = CW'(WIDTH - 1);
          quo_neg_d = div_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          rem_neg_d = div_signed & dividend[WIDTH-1];
          busy_d    = 1'b1;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH+1]};
        rem_d = trial[WIDTH+1] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_FIX: begin
        quotient_d  = quo_neg_q ? (~quo_q + 1'b1) : quo_q;
        remainder_d = rem_neg_q ? (~rem_q + 1'b1) : rem_q;
        state_d     = S_DONE;
      end
      S_DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      quo_neg_q   <= 1'b0;
      rem_neg_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      div_zero_q  <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      cnt_q       <= cnt_d;
      quo_neg_q   <= quo_neg_d;
      rem_neg_q   <= rem_neg_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      div_zero_q  <= div_zero_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign div_zero  = div_zero_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule

`default_nettype wire

// File: tb/tb_div_seq.sv
// tb_div_seq: directed self-checking bench for div_seq at WIDTH=32.
`default_nettype none

module tb_div_seq;

  localparam int WIDTH = 32;
  localparam int LAT   = WIDTH + 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             div_start;
  logic             div_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  int passed = 0;
  int total  = 0;

  div_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .div_start (div_start),
    .div_signed(div_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always #5 clk = ~clk;

  // Pulses div_start for one edge; returns during the first cycle after the sampling edge.
  task automatic start_div(input logic s, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clk);
    div_start  = 1'b1;
    div_signed = s;
    dividend   = a;
    divisor    = b;
    @(negedge clk);
    div_start  = 1'b0;
    dividend   = $urandom;
    divisor    = $urandom;
  endtask

  // Cycle index 0 is the first cycle after the sampling edge.
  task automatic wait_done(output int cycles, output int bcyc);
    cycles = 0;
    bcyc   = 0;
    while (done !== 1'b1 && cycles < 200) begin
      if (busy === 1'b1) bcyc++;
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    div_start = 1'b0; div_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else passed++;
    total++; if (div_zero !== 1'b0) $display("FAIL reset_div_zero: got %b expected 0", div_zero); else passed++;
    total++; if (quotient !== 32'h0) $display("FAIL reset_quotient: got %h expected 0", quotient); else passed++;
    total++; if (remainder !== 32'h0) $display("FAIL reset_remainder: got %h expected 0", remainder); else passed++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_unsigned;
    int cyc, bc;
    start_div(1'b0, 32'd100, 32'd7);
    wait_done(cyc, bc);
    total++; if (cyc !== LAT) $display("FAIL unsigned_latency: got %0d expected %0d", cyc, LAT); else passed++;
    total++; if (bc !== LAT) $display("FAIL unsigned_busy_cycles: got %0d expected %0d", bc, LAT); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL unsigned_busy_at_done: got %b expected 0", busy); else passed++;
    total++; if (quotient !== 32'd14) $display("FAIL unsigned_quotient: got %h expected %h", quotient, 32'd14); else passed++;
    total++; if (remainder !== 32'd2) $display("FAIL unsigned_remainder: got %h expected %h", remainder, 32'd2); else passed++;
    @(negedge clk);
    total++; if (done !== 1'b0) $display("FAIL unsigned_done_one_cycle: got %b expected 0", done); else passed++;
  endtask

  task automatic test_div_zero;
`ifdef DIV_ZERO_CHECK_EN
    int bhi, dhi, zhi;
    start_div(1'b0, 32'd5, 32'd0);
    total++; if (div_zero !== 1'b1) $display("FAIL divzero_pulse: got %b expected 1", div_zero); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL divzero_busy: got %b expected 0", busy); else passed++;
    bhi = 0; dhi = 0; zhi = 0;
    for (int i = 0; i < LAT + 4; i++) begin
      @(negedge clk);
      if (busy === 1'b1) bhi++;
      if (done === 1'b1) dhi++;
      if (div_zero === 1'b1) zhi++;
    end
    total++; if (bhi !== 0) $display("FAIL divzero_busy_later: got %0d cycles expected 0", bhi); else passed++;
    total++; if (dhi !== 0) $display("FAIL divzero_done: got %0d cycles expected 0", dhi); else passed++;
    total++; if (zhi !== 0) $display("FAIL divzero_pulse_width: got %0d extra cycles expected 0", zhi); else passed++;
    total++; if (quotient !== 32'd14) $display("FAIL divzero_quotient_held: got %h expected %h", quotient, 32'd14); else passed++;
    total++; if (remainder !== 32'd2) $display("FAIL divzero_remainder_held: got %h expected %h", remainder, 32'd2); else passed++;
`else
    int cyc, bc;
    start_div(1'b0, 32'd5, 32'd0);
    total++; if (div_zero !== 1'b0) $display("FAIL divzero_tied_low: got %b expected 0", div_zero); else passed++;
    wait_done(cyc, bc);
    total++; if (cyc !== LAT) $display("FAIL divzero_latency: got %0d expected %0d", cyc, LAT); else passed++;
    total++; if (quotient !== 32'hFFFF_FFFF) $display("FAIL divzero_quotient: got %h expected ffffffff", quotient); else passed++;
    total++; if (remainder !== 32'd5) $display("FAIL divzero_remainder: got %h expected 5", remainder); else passed++;
    total++; if (div_zero !== 1'b0) $display("FAIL divzero_flag_at_done: got %b expected 0", div_zero); else passed++;
`endif
  endtask

  task automatic test_signed;
    int cyc, bc;
    start_div(1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_done(cyc, bc);
    total++; if (cyc !== LAT) $display("FAIL signed_latency: got %0d expected %0d", cyc, LAT); else passed++;
    total++; if (quotient !== 32'hFFFF_FFFD) $display("FAIL signed_neg7_div2_quotient: got %h expected fffffffd", quotient); else passed++;
    total++; if (remainder !== 32'hFFFF_FFFF) $display("FAIL signed_neg7_div2_remainder: got %h expected ffffffff", remainder); else passed++;
    start_div(1'b1, 32'd7, 32'hFFFF_FFFE);
    wait_done(cyc, bc);
    total++; if (quotient !== 32'hFFFF_FFFD) $display("FAIL signed_7_divneg2_quotient: got %h expected fffffffd", quotient); else passed++;
    total++; if (remainder !== 32'd1) $display("FAIL signed_7_divneg2_remainder: got %h expected 1", remainder); else passed++;
    // Same operands unsigned: 0xFFFFFFF9 / 2 = 0x7FFFFFFC rem 1
    start_div(1'b0, 32'hFFFF_FFF9, 32'd2);
    wait_done(cyc, bc);
    total++; if (quotient !== 32'h7FFF_FFFC) $display("FAIL unsigned_big_quotient: got %h expected 7ffffffc", quotient); else passed++;
    total++; if (remainder !== 32'd1) $display("FAIL unsigned_big_remainder: got %h expected 1", remainder); else passed++;
  endtask

  task automatic test_overflow;
    int cyc, bc;
    start_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(cyc, bc);
    total++; if (done !== 1'b1) $display("FAIL overflow_done: got %b expected 1", done); else passed++;
    total++; if (div_zero !== 1'b0) $display("FAIL overflow_div_zero: got %b expected 0", div_zero); else passed++;
    total++; if (quotient !== 32'h8000_0000) $display("FAIL overflow_quotient: got %h expected 80000000", quotient); else passed++;
    total++; if (remainder !== 32'h0) $display("FAIL overflow_remainder: got %h expected 0", remainder); else passed++;
  endtask

  task automatic test_back_to_back;
    int cyc, bc, dhi;
    start_div(1'b0, 32'd100, 32'd7);
    repeat (2) @(negedge clk);
    div_start = 1'b1; div_signed = 1'b0; dividend = 32'd50; divisor = 32'd5;
    @(negedge clk);
    div_start = 1'b0;
    wait_done(cyc, bc);
    total++; if (cyc + 3 !== LAT) $display("FAIL b2b_latency: got %0d expected %0d", cyc + 3, LAT); else passed++;
    total++; if (quotient !== 32'd14) $display("FAIL b2b_quotient: got %h expected %h", quotient, 32'd14); else passed++;
    total++; if (remainder !== 32'd2) $display("FAIL b2b_remainder: got %h expected %h", remainder, 32'd2); else passed++;
    dhi = 0;
    for (int i = 0; i < LAT + 4; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dhi++;
    end
    total++; if (dhi !== 0) $display("FAIL b2b_no_second_op: got %0d active cycles expected 0", dhi); else passed++;
  endtask

  task automatic test_reset_mid_run;
    int cyc, bc;
    start_div(1'b0, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    total++; if (busy !== 1'b0) $display("FAIL midreset_busy: got %b expected 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL midreset_done: got %b expected 0", done); else passed++;
    total++; if (div_zero !== 1'b0) $display("FAIL midreset_div_zero: got %b expected 0", div_zero); else passed++;
    total++; if (quotient !== 32'h0) $display("FAIL midreset_quotient: got %h expected 0", quotient); else passed++;
    total++; if (remainder !== 32'h0) $display("FAIL midreset_remainder: got %h expected 0", remainder); else passed++;
    @(negedge clk);
    reset = 1'b0;
    start_div(1'b0, 32'd9, 32'd3);
    wait_done(cyc, bc);
    total++; if (cyc !== LAT) $display("FAIL post_reset_latency: got %0d expected %0d", cyc, LAT); else passed++;
    total++; if (quotient !== 32'd3) $display("FAIL post_reset_quotient: got %h expected 3", quotient); else passed++;
    total++; if (remainder !== 32'd0) $display("FAIL post_reset_remainder: got %h expected 0", remainder); else passed++;
  endtask

  initial begin
    test_reset;
    test_unsigned;
    test_div_zero;
    test_signed;
    test_overflow;
    test_back_to_back;
    test_reset_mid_run;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
